// File: rtl/tcm_sched_pkg.sv
// Shared types and constants for the GF(2)[x] 3x3-segment multiply scheduler.
// Zero-segment skipping in the scheduler is enabled by defining TCM_ZERO_SKIP_EN.
package tcm_sched_pkg;

    localparam int unsigned SEG_W_DEFAULT = 128;
    localparam int unsigned NUM_SUBPROD   = 9;
    localparam int unsigned K_W           = 4;
    localparam int unsigned SEG_IDX_W     = 2;

    typedef logic [K_W-1:0] k_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [SEG_IDX_W-1:0] i;
        logic [SEG_IDX_W-1:0] j;
    } seg_pair_t;

    localparam k_t K_LAST = K_W'(NUM_SUBPROD - 1);

    // Sub-product k pairs segment a[k/3] with segment b[k%3].
    function automatic seg_pair_t k_to_ij(input k_t k);
        seg_pair_t p;
        p.i = SEG_IDX_W'(k / K_W'(3));
        p.j = SEG_IDX_W'(k % K_W'(3));
        return p;
    endfunction

endpackage

// File: rtl/clmul_bitserial.sv
// Bit-serial SEG_W x SEG_W carry-less multiplier: one multiplier bit per step, LSB first.
// The partial product and bit index are both returned to zero by clear_i.
module clmul_bitserial
    import tcm_sched_pkg::*;
#(
    parameter  int unsigned SEG_W = SEG_W_DEFAULT,
    localparam int unsigned PP_W  = 2 * SEG_W - 1,
    localparam int unsigned BIT_W = (SEG_W > 1) ? $clog2(SEG_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [SEG_W-1:0] a_seg_i,
    input  logic [SEG_W-1:0] b_seg_i,
    output logic [BIT_W-1:0] bit_idx_o,
    output logic [PP_W-1:0]  pp_o
);

    logic [BIT_W-1:0] bit_q, bit_d;
    logic [PP_W-1:0]  pp_q,  pp_d;

    // pp ^= b << bit whenever the current multiplier bit is set
    always_comb begin
        bit_d = bit_q;
        pp_d  = pp_q;
        if (clear_i) begin
            bit_d = '0;
            pp_d  = '0;
        end else if (step_i) begin
            if (a_seg_i[bit_q]) begin
                pp_d = pp_q ^ (PP_W'(b_seg_i) << bit_q);
            end
            bit_d = (bit_q == BIT_W'(SEG_W - 1)) ? '0 : bit_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= '0;
            pp_q  <= '0;
        end else begin
            bit_q <= bit_d;
            pp_q  <= pp_d;
        end
    end

    assign bit_idx_o = bit_q;
    assign pp_o      = pp_q;

endmodule

// File: rtl/tcm_gf2_scheduler.sv
// 3*SEG_W x 3*SEG_W carry-less multiplier built from nine time-shared segment products.
// Define TCM_ZERO_SKIP_EN to bypass sub-products whose a or b segment is zero.
module tcm_gf2_scheduler
    import tcm_sched_pkg::*;
#(
    parameter int unsigned SEG_W = SEG_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3*SEG_W-1:0]   a,
    input  logic [3*SEG_W-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [6*SEG_W-1:0]   c
);

    localparam int unsigned OP_W  = 3 * SEG_W;
    localparam int unsigned ACC_W = 6 * SEG_W;
    localparam int unsigned PP_W  = 2 * SEG_W - 1;
    localparam int unsigned BIT_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    k_t                k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  c_q, c_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_c;
    logic              last_bit_c;
    logic              clr_c;
    logic              step_c;
    seg_pair_t         ij_c;
    logic [31:0]       shamt_c;
    logic [SEG_W-1:0]  seg_a_c;
    logic [SEG_W-1:0]  seg_b_c;
    logic [BIT_W-1:0]  bit_idx;
    logic [PP_W-1:0]   pp;

`ifdef TCM_ZERO_SKIP_EN
    // A zero segment makes its sub-product zero, so the multiply can be bypassed.
    function automatic logic seg_zero(input logic [OP_W-1:0] av,
                                      input logic [OP_W-1:0] bv,
                                      input k_t k);
        seg_pair_t p;
        p = k_to_ij(k);
        return (av[32'(p.i) * SEG_W +: SEG_W] == '0) ||
               (bv[32'(p.j) * SEG_W +: SEG_W] == '0);
    endfunction
`endif

    // A start coinciding with the done pulse is deliberately refused.
    assign accept_c   = (state_q == IDLE) && start && !done_q;
    assign last_bit_c = (bit_idx == BIT_W'(SEG_W - 1));
    assign ij_c       = k_to_ij(k_q);
    assign shamt_c    = (32'(ij_c.i) + 32'(ij_c.j)) * SEG_W;
    assign seg_a_c    = a_q[32'(ij_c.i) * SEG_W +: SEG_W];
    assign seg_b_c    = b_q[32'(ij_c.j) * SEG_W +: SEG_W];

    clmul_bitserial #(
        .SEG_W (SEG_W)
    ) u_clmul (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clr_c),
        .step_i    (step_c),
        .a_seg_i   (seg_a_c),
        .b_seg_i   (seg_b_c),
        .bit_idx_o (bit_idx),
        .pp_o      (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: MUL for SEG_W cycles, then one ACC cycle per sub-product.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
`ifdef TCM_ZERO_SKIP_EN
                    state_d = seg_zero(a, b, '0) ? ACC : MUL;
`else
                    state_d = MUL;
`endif
                end
            end
            MUL: begin
                if (last_bit_c) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
`ifdef TCM_ZERO_SKIP_EN
                    state_d = seg_zero(a_q, b_q, k_q + K_W'(1)) ? ACC : MUL;
`else
                    state_d = MUL;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In a skipped ACC the partial product is still clear, so its XOR is a no-op.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        acc_d  = acc_q;
        c_d    = c_q;
        busy_d = busy_q;
        done_d = 1'b0;
        clr_c  = 1'b0;
        step_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d    = a;
                    b_d    = b;
                    k_d    = '0;
                    acc_d  = '0;
                    busy_d = 1'b1;
                    clr_c  = 1'b1;
                end
            end
            MUL: begin
                step_c = 1'b1;
            end
            ACC: begin
                acc_d = acc_q ^ (ACC_W'(pp) << shamt_c);
                clr_c = 1'b1;
                if (k_q != K_LAST) begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                c_d    = acc_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            c_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            acc_q  <= acc_d;
            c_q    <= c_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule

// File: tb/tb_tcm_gf2_scheduler.sv
// Scoreboard bench for tcm_gf2_scheduler: driver queues expected product and latency,
// a negedge monitor checks them at each done pulse. Honours TCM_ZERO_SKIP_EN.
module tb_tcm_gf2_scheduler;

    localparam int unsigned SEG_W  = 128;
    localparam int unsigned OP_W   = 3 * SEG_W;
    localparam int unsigned ACC_W  = 6 * SEG_W;
    localparam int          N_FULL = 1162;
    localparam int          LIM    = 4000;
    localparam int          N_RAND = 40;
`ifdef TCM_ZERO_SKIP_EN
    localparam int          LAT_ONE = 138;
`else
    localparam int          LAT_ONE = 1162;
`endif

    typedef struct {
        logic [ACC_W-1:0] c;
        int               lat;
        int               acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] c;

    exp_t             sb_q[$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    logic             busy_bad = 1'b0;
    logic [ACC_W-1:0] last_c = '0;

    tcm_gf2_scheduler #(.SEG_W(SEG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [ACC_W-1:0] act,
                                input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference: whole-operand shift-and-XOR polynomial product.
    function automatic logic [ACC_W-1:0] clmul_ref(input logic [OP_W-1:0] x,
                                                   input logic [OP_W-1:0] y);
        logic [ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(OP_W); i++)
            if (x[i]) r = r ^ (ACC_W'(y) << i);
        return r;
    endfunction

    function automatic int exp_lat(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
        int lat;
`ifdef TCM_ZERO_SKIP_EN
        lat = 1;
        for (int k = 0; k < 9; k++) begin
            if (x[(k / 3) * SEG_W +: SEG_W] == '0 || y[(k % 3) * SEG_W +: SEG_W] == '0)
                lat += 1;
            else
                lat += SEG_W + 1;
        end
`else
        lat = 9 * (SEG_W + 1) + 1;
`endif
        return lat;
    endfunction

    function automatic logic [OP_W-1:0] rand_op();
        logic [OP_W-1:0] v;
        for (int w = 0; w < int'(OP_W / 32); w++) v[w * 32 +: 32] = $urandom;
        for (int s = 0; s < 3; s++)
            if ($urandom_range(3) == 0) v[s * SEG_W +: SEG_W] = '0;
        return v;
    endfunction

    // Monitor: pop one expectation per done pulse; track busy while work is pending.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", ACC_W'(done), ACC_W'(0));
            end else begin
                e = sb_q.pop_front();
                chk("product", c, e.c);
                chk("latency", ACC_W'(cyc - e.acc_cyc), ACC_W'(e.lat));
                chk("busy_held", ACC_W'(busy_bad), ACC_W'(0));
                chk("busy_after_done", ACC_W'(busy), ACC_W'(0));
            end
            busy_bad = 1'b0;
        end else if (sb_q.size() != 0 && !busy) begin
            busy_bad = 1'b1;
        end
    end

    task automatic issue(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv,
                         input logic [ACC_W-1:0] ec, input int el);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_start", ACC_W'({busy, done}), ACC_W'(0));
        start = 1'b1;
        op_a  = av;
        op_b  = bv;
        @(posedge clk);
        #1;
        e.c = ec;
        e.lat = el;
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = rand_op();
        op_b  = rand_op();
        last_c = ec;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("op_complete", ACC_W'(sb_q.size()), ACC_W'(0));
        sb_q.delete();
        repeat (3) @(negedge clk);
        chk("c_hold", c, last_c);
    endtask

    initial begin
        logic [OP_W-1:0]  va, vb;
        logic [ACC_W-1:0] vc;
        int n;

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", ACC_W'(busy), ACC_W'(0));
        chk("reset_done", ACC_W'(done), ACC_W'(0));
        chk("reset_c", c, ACC_W'(0));
        rst = 1'b0;

        issue(OP_W'(1), OP_W'(1), ACC_W'(1), LAT_ONE);
        wait_done();

        va = '0; va[OP_W - 1] = 1'b1;
        vc = '0; vc[2 * OP_W - 2] = 1'b1;
        issue(va, va, vc, exp_lat(va, va));
        wait_done();

        issue(OP_W'(3), OP_W'(3), ACC_W'(5), exp_lat(OP_W'(3), OP_W'(3)));
        wait_done();

        va = '1;
        issue(va, OP_W'(1), ACC_W'(va), exp_lat(va, OP_W'(1)));
        wait_done();

        // A second start ten cycles in must not restart or add a result.
        va = rand_op(); vb = rand_op();
        issue(va, vb, clmul_ref(va, vb), exp_lat(va, vb));
        repeat (9) @(negedge clk);
        start = 1'b1; op_a = rand_op(); op_b = rand_op();
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // A start held during the done cycle must be refused.
        va = rand_op(); vb = rand_op();
        issue(va, vb, clmul_ref(va, vb), exp_lat(va, vb));
        n = 0;
        while (!done && n < LIM) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; op_a = OP_W'(5); op_b = OP_W'(7);
        @(posedge clk);
        #1;
        chk("start_on_done_ignored", ACC_W'(busy), ACC_W'(0));
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Abort mid-operation with an asynchronous reset.
        va = '1;
        issue(va, va, clmul_ref(va, va), N_FULL);
        repeat (498) @(negedge clk);
        sb_q.delete();
        busy_bad = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", ACC_W'(busy), ACC_W'(0));
        chk("abort_done", ACC_W'(done), ACC_W'(0));
        chk("abort_c", c, ACC_W'(0));
        @(negedge clk);
        rst = 1'b0;
        last_c = '0;
        issue(OP_W'(3), OP_W'(3), ACC_W'(5), exp_lat(OP_W'(3), OP_W'(3)));
        wait_done();

        va = '1;
        issue(va, va, clmul_ref(va, va), N_FULL);
        wait_done();

        for (int r = 0; r < N_RAND; r++) begin
            va = rand_op(); vb = rand_op();
            issue(va, vb, clmul_ref(va, vb), exp_lat(va, vb));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/tcm_gf2_scheduler.md
TCM_GF2_SCHEDULER -- requirements
Module: tcm_gf2_scheduler

Interface
REQ-001 SHALL have parameter SEG_W, default 128, meaning the width of one operand segment; operands are 3*SEG_W bits wide.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  meaning a request to multiply a by b.
REQ-005 SHALL have port a  input  3*SEG_W  meaning operand A, segments a0=[SEG_W-1:0], a1, a2.
REQ-006 SHALL have port b  input  3*SEG_W  meaning operand B, segments b0, b1, b2.
REQ-007 SHALL have port busy  output  1  meaning an operation is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle pulse when c is updated.
REQ-009 SHALL have port c  output  6*SEG_W  meaning the carry-less (GF(2)[x]) product a*b.

Function
REQ-010 SHALL compute c as the XOR over all segment pairs (i,j), i and j in 0..2, of (ai clmul bj) << ((i+j)*SEG_W).
REQ-011 SHALL time-share one bit-serial SEG_W x SEG_W carry-less multiplier across the 9 sub-products, in fixed order k=0..8, with i=k/3 and j=k%3.
REQ-012 SHALL use states IDLE, MUL, ACC and DONE.
REQ-013 In IDLE with start=1: capture a and b into internal registers, clear the accumulator and the partial product, set k=0 and bit count 0, set busy=1, and go to MUL.
REQ-014 MUL SHALL process one bit per cycle, LSB first: if ai[bit]=1 then pp ^= bj<<bit; after bit SEG_W-1 it SHALL go to ACC, so MUL lasts exactly SEG_W cycles.
REQ-015 ACC (one cycle) SHALL XOR pp<<((i+j)*SEG_W) into the 6*SEG_W accumulator and clear pp; it SHALL go to DONE if k=8, otherwise increment k and return to MUL.
REQ-016 DONE (one cycle) SHALL load c from the accumulator, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-017 Latency SHALL be N = 9*(SEG_W+1)+1 edges from the start-accept edge to the edge that raises done; N = 1162 for SEG_W=128.
REQ-018 SHALL ignore start while busy=1; a and b changing during an operation SHALL NOT affect the result.
REQ-019 c SHALL hold its value between done pulses.
REQ-020 start asserted in the same cycle as done is not accepted; start is accepted no earlier than the cycle after done.
REQ-021 The accumulator SHALL be 6*SEG_W bits wide, and no bits SHALL be dropped: the top sub-product fits in bits [6*SEG_W-2:4*SEG_W].

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, busy=0, done=0, c=0, the accumulator, pp, k and the bit count to 0.
REQ-023 Reset mid-operation SHALL abort with no done pulse; the next accepted start SHALL produce a correct result with full latency.

Configuration
REQ-024 Macro TCM_ZERO_SKIP_EN SHALL control zero-segment skipping.
REQ-025 With TCM_ZERO_SKIP_EN defined: on entry to sub-product k, if ai=0 or bj=0, the block SHALL skip MUL and spend exactly one cycle (ACC with no XOR) before advancing; latency becomes data-dependent.
REQ-026 With TCM_ZERO_SKIP_EN undefined: latency SHALL always be N (REQ-017).
REQ-027 Results SHALL be bit-identical with and without TCM_ZERO_SKIP_EN.

Structure
REQ-028 Package tcm_sched_pkg SHALL hold the SEG_W default, the NUM_SUBPROD=9 constant, the state enum typedef, and the k-to-(i,j) mapping function.
REQ-029 Sub-module clmul_bitserial SHALL implement the SEG_W x SEG_W bit-serial carry-less step engine: clear, step, bit index, and pp output.
REQ-030 tcm_gf2_scheduler SHALL own the FSM, operand segment muxing and the accumulator.

Verification
REQ-031 a=1, b=1, start one cycle -> done pulses once, 1162 edges after accept; c=1; busy=1 throughout.
REQ-032 a=1<<383, b=1<<383 -> c=1<<766; a=3, b=3 -> c=5 (carry-less, not 9).
REQ-033 a = all-ones (384 bits), b=1 -> c[383:0] all ones and c[767:384]=0; random a,b (1000 runs) -> c matches a software clmul reference.
REQ-034 start pulsed again at cycle 10 of an operation -> ignored, single done, first result correct; start on the done cycle -> not accepted.
REQ-035 rst asserted at cycle 500 of an operation -> busy=0, done=0, c=0 at once; a new operation with a=3, b=3 -> c=5 after 1162 edges.
REQ-036 With TCM_ZERO_SKIP_EN defined, a=1, b=1 -> done after 138 edges, c=1; a=b=all-ones -> done after 1162 edges.
